sha256_pad: RTL and testbench

- Upstream stage for the sha256 core: message padder.
- Accepts a raw message as a big-endian 32-bit word stream of arbitrary byte length.
- Emits the FIPS 180-4 padded message as 512-bit blocks, 16 words per block, on the same valid/ready/last stream protocol that the sha256 core's in_* port consumes.
- Padding: 0x80 marker byte, zero fill, then 64-bit big-endian bit length. out_last_o marks the final word of the final block.

---
 rtl/sha256_pad.sv | 179 +++++++++++++++++
 tb/tb_sha256_pad.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_pad.sv
// -----------------------------------------------------------------------------
// sha256_pad
// Message padder in front of the sha256 core. Takes a big-endian 32-bit word
// stream of arbitrary byte length and emits the padded message (0x80 marker,
// zero fill, 64-bit big-endian bit length) as 16-word blocks on a
// valid/ready/last stream.
//
// Ports
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   in_data_i    message word, byte 0 in [31:24]
//   in_bytes_i   valid bytes of the last word (0..4, 5..7 treated as 4)
//   in_last_i    final message word
//   in_valid_i   input word valid
//   in_ready_o   input word accepted
//   out_data_o   padded word
//   out_last_o   last word of the padded message
//   out_valid_o  output word valid
//   out_ready_i  downstream ready
//
// Message words pass through combinationally with zero latency; the marker,
// zero fill and length words are generated from the FSM state after the last
// input word has been accepted.
// -----------------------------------------------------------------------------
module sha256_pad #(
    parameter int D_WIDTH = 32,
    parameter int L_WIDTH = 64
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [D_WIDTH-1:0] in_data_i,
    input  logic [2:0]         in_bytes_i,
    input  logic               in_last_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [D_WIDTH-1:0] out_data_o,
    output logic               out_last_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    // Bytes are counted; the bit length is the byte count shifted by three.
    localparam int BC_WIDTH = L_WIDTH - 3;

    typedef enum logic [1:0] {
        ST_DATA   = 2'd0,
        ST_PAD    = 2'd1,
        ST_LEN_HI = 2'd2,
        ST_LEN_LO = 2'd3
    } state_t;

    state_t                state_r;
    logic [3:0]            wcnt_r;
    logic [BC_WIDTH-1:0]   byte_cnt_r;
    logic                  padded_r;

    logic [2:0]            last_bytes_s;
    logic [3:0]            wcnt_inc_s;
    logic [L_WIDTH-1:0]    bit_len_s;
    logic                  out_xfer_s;
    logic                  last_partial_s;

    // Insert the 0x80 marker right after the n valid bytes of the last word.
    function automatic logic [31:0] pad_last_word(input logic [31:0] d,
                                                  input logic [2:0]  n);
        logic [31:0] w;
        case (n)
            3'd0:    w = 32'h8000_0000;
            3'd1:    w = {d[31:24], 24'h80_0000};
            3'd2:    w = {d[31:16], 16'h8000};
            3'd3:    w = {d[31:8], 8'h80};
            default: w = d;
        endcase
        return w;
    endfunction

    // Derived values: clamped byte count, next word index, bit length, transfer strobe.
    always_comb begin
        if (in_bytes_i[2]) begin
            last_bytes_s = 3'd4;
        end else begin
            last_bytes_s = in_bytes_i;
        end
        last_partial_s = (last_bytes_s != 3'd4);
        wcnt_inc_s     = wcnt_r + 4'd1;
        bit_len_s      = {byte_cnt_r, 3'b000};
        out_xfer_s     = out_valid_o & out_ready_i;
    end

    // Output and handshake decode; DATA is a zero-latency pass-through.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = 32'h0000_0000;
        out_last_o  = 1'b0;
        case (state_r)
            ST_DATA: begin
                in_ready_o  = out_ready_i;
                out_valid_o = in_valid_i;
                if (in_last_i) begin
                    out_data_o = pad_last_word(in_data_i, last_bytes_s);
                end else begin
                    out_data_o = in_data_i;
                end
            end
            ST_PAD: begin
                out_valid_o = 1'b1;
                if (padded_r) begin
                    out_data_o = 32'h0000_0000;
                end else begin
                    out_data_o = 32'h8000_0000;
                end
            end
            ST_LEN_HI: begin
                out_valid_o = 1'b1;
                out_data_o  = bit_len_s[L_WIDTH-1:L_WIDTH-32];
            end
            ST_LEN_LO: begin
                out_valid_o = 1'b1;
                out_data_o  = bit_len_s[31:0];
                out_last_o  = 1'b1;
            end
            default: begin
                out_valid_o = 1'b0;
            end
        endcase
    end

    // Padding FSM, word index, byte counter and marker-emitted flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r    <= ST_DATA;
            wcnt_r     <= 4'd0;
            byte_cnt_r <= '0;
            padded_r   <= 1'b0;
        end else if (out_xfer_s) begin
            wcnt_r <= wcnt_inc_s;
            case (state_r)
                ST_DATA: begin
                    if (in_last_i) begin
                        byte_cnt_r <= byte_cnt_r + BC_WIDTH'(last_bytes_s);
                        padded_r   <= last_partial_s;
                        // A partial last word at index 13 already carries the
                        // marker, so the length follows immediately.
                        if ((wcnt_inc_s == 4'd14) && last_partial_s) begin
                            state_r <= ST_LEN_HI;
                        end else begin
                            state_r <= ST_PAD;
                        end
                    end else begin
                        byte_cnt_r <= byte_cnt_r + BC_WIDTH'(3'd4);
                    end
                end
                ST_PAD: begin
                    // Every PAD word leaves the marker emitted.
                    padded_r <= 1'b1;
                    if (wcnt_inc_s == 4'd14) begin
                        state_r <= ST_LEN_HI;
                    end else begin
                        state_r <= ST_PAD;
                    end
                end
                ST_LEN_HI: begin
                    state_r <= ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    wcnt_r     <= 4'd0;
                    byte_cnt_r <= '0;
                    padded_r   <= 1'b0;
                    state_r    <= ST_DATA;
                end
                default: begin
                    state_r <= ST_DATA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_pad.sv
module tb_sha256_pad;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] in_data_i;
    logic [2:0]  in_bytes_i;
    logic        in_last_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] out_data_o;
    logic        out_last_o;
    logic        out_valid_o;
    logic        out_ready_i;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] msg    [16];
    logic [31:0] got_d  [40];
    logic        got_l  [40];
    logic [31:0] exp_d  [40];
    int          ngot;
    bit          timed_out;
    int          stall_viol;
    int          ready_viol;

    sha256_pad dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .in_data_i   (in_data_i),
        .in_bytes_i  (in_bytes_i),
        .in_last_i   (in_last_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic clear_exp();
        for (int i = 0; i < 40; i++) exp_d[i] = 32'h0;
    endtask

    // Drive nwords of msg[], collect output transfers until last (or stop_after).
    task automatic run_msg(input int nwords, input logic [2:0] lbytes,
                           input bit stall, input int stop_after);
        int          idx;
        int          cyc;
        bit          done;
        bit          stalled;
        logic [31:0] held;
        idx = 0; cyc = 0; done = 1'b0; stalled = 1'b0; held = 32'h0;
        ngot = 0; timed_out = 1'b0; stall_viol = 0; ready_viol = 0;
        for (int i = 0; i < 40; i++) begin
            got_d[i] = 32'hxxxx_xxxx;
            got_l[i] = 1'bx;
        end
        while (!done) begin
            @(posedge clk_i); #1;
            in_valid_i  = (idx < nwords);
            in_data_i   = (idx < nwords) ? msg[idx] : 32'h0;
            in_last_i   = (idx == nwords - 1);
            in_bytes_i  = lbytes;
            out_ready_i = stall ? cyc[0] : 1'b1;
            @(negedge clk_i);
            if (stalled && (out_data_o !== held)) stall_viol++;
            if ((idx >= nwords) && (in_ready_o !== 1'b0)) ready_viol++;
            stalled = out_valid_o && !out_ready_i;
            held    = out_data_o;
            if (out_valid_o && out_ready_i) begin
                got_d[ngot] = out_data_o;
                got_l[ngot] = out_last_o;
                ngot++;
                if (out_last_o || (ngot == stop_after) || (ngot >= 40)) done = 1'b1;
            end
            if (in_valid_i && in_ready_o) idx++;
            cyc++;
            if ((cyc > 400) && !done) begin
                timed_out = 1'b1;
                done = 1'b1;
            end
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        out_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b0;
        in_data_i = 32'h0; in_bytes_i = 3'd0; in_last_i = 1'b0;
        #12;
        n_assert++;
        if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || out_last_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: valid=%b ready=%b last=%b, expected 1 0 0", out_valid_o, in_ready_o, out_last_o);
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1; #1;
        n_assert++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || out_last_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: valid=%b ready=%b last=%b, expected 0 1 0", out_valid_o, in_ready_o, out_last_o);
        end
        @(negedge clk_i); rst_n_i = 1'b1;
    endtask

    task automatic test_abc();
        msg[0] = 32'h6162_6300;
        clear_exp(); exp_d[0] = 32'h6162_6380; exp_d[15] = 32'h0000_0018;
        run_msg(1, 3'd3, 1'b0, 0);
        n_assert++;
        if (timed_out || ngot != 16) begin
            n_fail++; $display("FAIL abc_count: got %0d words timeout=%0d, expected 16", ngot, timed_out);
        end
        for (int i = 0; i < 16; i++) begin
            n_assert++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 15)) begin
                n_fail++;
                $display("FAIL abc_w%0d: got %h last=%b, expected %h last=%b", i, got_d[i], got_l[i], exp_d[i], (i == 15));
            end
        end
    endtask

    task automatic test_empty();
        msg[0] = 32'hDEAD_BEEF;
        clear_exp(); exp_d[0] = 32'h8000_0000;
        run_msg(1, 3'd0, 1'b0, 0);
        n_assert++;
        if (timed_out || ngot != 16) begin
            n_fail++; $display("FAIL empty_count: got %0d words timeout=%0d, expected 16", ngot, timed_out);
        end
        for (int i = 0; i < 16; i++) begin
            n_assert++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 15)) begin
                n_fail++;
                $display("FAIL empty_w%0d: got %h last=%b, expected %h last=%b", i, got_d[i], got_l[i], exp_d[i], (i == 15));
            end
        end
    endtask

    task automatic test_56(input bit stall);
        clear_exp();
        for (int i = 0; i < 14; i++) begin
            msg[i]   = 32'h0102_0304 + 32'h0404_0404 * i;
            exp_d[i] = 32'h0102_0304 + 32'h0404_0404 * i;
        end
        exp_d[14] = 32'h8000_0000; exp_d[31] = 32'h0000_01C0;
        run_msg(14, 3'd4, stall, 0);
        n_assert++;
        if (timed_out || ngot != 32) begin
            n_fail++; $display("FAIL b56_count stall=%0d: got %0d words timeout=%0d, expected 32", stall, ngot, timed_out);
        end
        for (int i = 0; i < 32; i++) begin
            n_assert++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 31)) begin
                n_fail++;
                $display("FAIL b56_w%0d stall=%0d: got %h last=%b, expected %h last=%b", i, stall, got_d[i], got_l[i], exp_d[i], (i == 31));
            end
        end
        n_assert++;
        if (stall_viol != 0 || ready_viol != 0) begin
            n_fail++;
            $display("FAIL b56_hold stall=%0d: unstable=%0d ready_in_pad=%0d, expected 0 0", stall, stall_viol, ready_viol);
        end
    endtask

    task automatic test_55();
        clear_exp();
        for (int i = 0; i < 13; i++) begin
            msg[i]   = 32'hA000_0000 + i;
            exp_d[i] = 32'hA000_0000 + i;
        end
        msg[13] = 32'hAABB_CCDD; exp_d[13] = 32'hAABB_CC80; exp_d[15] = 32'h0000_01B8;
        run_msg(14, 3'd3, 1'b0, 0);
        n_assert++;
        if (timed_out || ngot != 16) begin
            n_fail++; $display("FAIL b55_count: got %0d words timeout=%0d, expected 16", ngot, timed_out);
        end
        for (int i = 0; i < 16; i++) begin
            n_assert++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 15)) begin
                n_fail++;
                $display("FAIL b55_w%0d: got %h last=%b, expected %h last=%b", i, got_d[i], got_l[i], exp_d[i], (i == 15));
            end
        end
    endtask

    // in_bytes_i = 7 behaves as a full 4-byte last word.
    task automatic test_bytes_clamp();
        msg[0] = 32'h1122_3344;
        clear_exp(); exp_d[0] = 32'h1122_3344; exp_d[1] = 32'h8000_0000; exp_d[15] = 32'h0000_0020;
        run_msg(1, 3'd7, 1'b0, 0);
        n_assert++;
        if (timed_out || ngot != 16) begin
            n_fail++; $display("FAIL clamp_count: got %0d words timeout=%0d, expected 16", ngot, timed_out);
        end
        for (int i = 0; i < 16; i++) begin
            n_assert++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 15)) begin
                n_fail++;
                $display("FAIL clamp_w%0d: got %h last=%b, expected %h last=%b", i, got_d[i], got_l[i], exp_d[i], (i == 15));
            end
        end
    endtask

    task automatic test_reset_mid_pad();
        for (int i = 0; i < 14; i++) msg[i] = 32'h5500_0000 + i;
        run_msg(14, 3'd4, 1'b0, 18);
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        #1;
        n_assert++;
        if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_pad_pre: valid=%b ready=%b, expected 1 0", out_valid_o, in_ready_o);
        end
        #1; rst_n_i = 1'b0; #1;
        n_assert++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || out_last_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_pad_now: valid=%b ready=%b last=%b, expected 0 1 0", out_valid_o, in_ready_o, out_last_o);
        end
        @(negedge clk_i); rst_n_i = 1'b1;
        msg[0] = 32'h6162_6300;
        clear_exp(); exp_d[0] = 32'h6162_6380; exp_d[15] = 32'h0000_0018;
        run_msg(1, 3'd3, 1'b0, 0);
        n_assert++;
        if (timed_out || ngot != 16) begin
            n_fail++; $display("FAIL rst_abc_count: got %0d words timeout=%0d, expected 16", ngot, timed_out);
        end
        for (int i = 0; i < 16; i++) begin
            n_assert++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 15)) begin
                n_fail++;
                $display("FAIL rst_abc_w%0d: got %h last=%b, expected %h last=%b", i, got_d[i], got_l[i], exp_d[i], (i == 15));
            end
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_56(1'b0);
        test_55();
        test_56(1'b1);
        test_bytes_clamp();
        test_reset_mid_pad();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
